// File: rtl/wb_write_queue_if.sv
// Bus bundle for the write-back queue: request handshake, drain port to the
// register bank, forwarding lookup and occupancy status.
interface wb_write_queue_if #(
    parameter int DEPTH = 4,
    parameter int NREGS = 8,
    parameter int AW    = 3
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Handshake: a request transfers on a rising edge where in_valid && in_ready.
    // in_ready depends only on occupancy, never on stall in the same cycle.
    logic             in_valid;
    logic             in_ready;
    logic [AW-1:0]    in_addr;
    logic [15:0]      in_data;
    logic             stall;
    logic [NREGS-1:0] wr_en;
    logic [15:0]      wr_d;
    logic [AW-1:0]    fwd_addr;
    logic             fwd_hit;
    logic [15:0]      fwd_data;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;

    modport slave (
        input  in_valid, in_addr, in_data, stall, fwd_addr,
        output in_ready, wr_en, wr_d, fwd_hit, fwd_data, count, full, empty
    );

    modport master (
        output in_valid, in_addr, in_data, stall, fwd_addr,
        input  in_ready, wr_en, wr_d, fwd_hit, fwd_data, count, full, empty
    );
endinterface

// File: rtl/wb_write_queue.sv
// Write-back FIFO in front of the register bank: drains one entry per cycle as a
// one-hot enable pulse and forwards the newest pending value for a read address.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int NREGS = 8,
    parameter int AW    = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    wb_write_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    r_addr [DEPTH];
    logic [15:0]      r_data [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [NREGS-1:0] r_wr_en;
    logic [15:0]      r_wr_d;
    logic [AW-1:0]    r_out_addr;

    logic             w_in_ready;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [NREGS-1:0] w_head_onehot;
    logic [PW-1:0]    w_idx;
    logic             w_fwd_hit;
    logic [15:0]      w_fwd_data;

    assign w_in_ready    = (r_count < CW'(DEPTH));
    assign w_empty       = (r_count == '0);
    assign w_push        = bus.in_valid && w_in_ready;
    assign w_pop         = !w_empty && !bus.stall;
    assign w_head_onehot = NREGS'(1) << r_addr[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wr_en    <= '0;
            r_wr_d     <= '0;
            r_out_addr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // The output stage keeps its address so forwarding can match it while the pulse is live.
            if (w_pop) begin
                r_wr_en    <= w_head_onehot;
                r_wr_d     <= r_data[r_rd_ptr];
                r_out_addr <= r_addr[r_rd_ptr];
            end else begin
                r_wr_en    <= '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_push) begin
            r_addr[r_wr_ptr] <= bus.in_addr;
            r_data[r_wr_ptr] <= bus.in_data;
        end
    end

    // Walk oldest to newest so the youngest matching entry overrides everything before it.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        w_idx      = '0;
        if ((r_wr_en != '0) && (r_out_addr == bus.fwd_addr)) begin
            w_fwd_hit  = 1'b1;
            w_fwd_data = r_wr_d;
        end
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_rd_ptr + PW'(k);
            if ((CW'(k) < r_count) && (r_addr[w_idx] == bus.fwd_addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_data[w_idx];
            end
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.wr_en    = r_wr_en;
    assign bus.wr_d     = r_wr_d;
    assign bus.fwd_hit  = w_fwd_hit;
    assign bus.fwd_data = w_fwd_data;
    assign bus.count    = r_count;
    assign bus.full     = (r_count == CW'(DEPTH));
    assign bus.empty    = w_empty;
endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: directed scenarios plus random traffic, all checked
// against a queue-based model of pending writes and the drain pulse.
module tb_wb_write_queue;
    localparam int DEPTH = 4;
    localparam int NREGS = 8;
    localparam int AW    = 3;

    logic clk;
    logic rst_n;

    wb_write_queue_if #(.DEPTH(DEPTH), .NREGS(NREGS), .AW(AW)) bus ();

    wb_write_queue #(.DEPTH(DEPTH), .NREGS(NREGS), .AW(AW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_pass;

    // Model: pending entries {addr,data} oldest first, plus the drain pulse in flight.
    logic [18:0] exp_q[$];
    logic        m_en;
    logic [2:0]  m_addr;
    logic [15:0] m_d;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic void model_fwd(input logic [2:0] fa, output logic hit, output logic [15:0] d);
        hit = 1'b0;
        d   = 16'h0;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i][18:16] == fa) begin
                hit = 1'b1;
                d   = exp_q[i][15:0];
                break;
            end
        end
        if (!hit && m_en && (m_addr == fa)) begin
            hit = 1'b1;
            d   = m_d;
        end
    endfunction

    task automatic check_regs();
        logic [7:0] exp_en;
        exp_en = m_en ? (8'h01 << m_addr) : 8'h00;
        check("wr_en", 32'(bus.wr_en), 32'(exp_en));
        check("wr_d", 32'(bus.wr_d), 32'(m_d));
        check("count", 32'(bus.count), 32'(exp_q.size()));
        check("full", 32'(bus.full), 32'(exp_q.size() == DEPTH));
        check("empty", 32'(bus.empty), 32'(exp_q.size() == 0));
    endtask

    // One clock cycle: drive, check combinational outputs, advance model, check registered outputs.
    task automatic step(input logic v, input logic [2:0] a, input logic [15:0] d,
                        input logic st, input logic [2:0] fa);
        logic        push;
        logic        pop;
        logic        hit;
        logic [15:0] fd;
        logic [18:0] e;
        bus.in_valid = v;
        bus.in_addr  = a;
        bus.in_data  = d;
        bus.stall    = st;
        bus.fwd_addr = fa;
        #1;
        model_fwd(fa, hit, fd);
        check("in_ready", 32'(bus.in_ready), 32'(exp_q.size() < DEPTH));
        check("fwd_hit", 32'(bus.fwd_hit), 32'(hit));
        check("fwd_data", 32'(bus.fwd_data), 32'(fd));
        push = v && (exp_q.size() < DEPTH);
        pop  = (exp_q.size() > 0) && !st;
        @(posedge clk);
        #1;
        if (pop) begin
            e      = exp_q.pop_front();
            m_en   = 1'b1;
            m_addr = e[18:16];
            m_d    = e[15:0];
        end else begin
            m_en = 1'b0;
        end
        if (push) exp_q.push_back({a, d});
        check_regs();
    endtask

    task automatic do_reset(input logic v);
        bus.in_valid = v;
        bus.in_addr  = 3'($urandom_range(0, 7));
        bus.in_data  = 16'($urandom);
        bus.stall    = 1'b0;
        rst_n        = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        m_en = 1'b0;
        m_d  = 16'h0;
        check_regs();
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_fwd_hit", 32'(bus.fwd_hit), 32'd0);
    endtask

    task automatic idle(input int n, input logic [2:0] fa);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 16'h0, 1'b0, fa);
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        m_en         = 1'b0;
        m_addr       = 3'd0;
        m_d          = 16'h0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_addr  = '0;
        bus.in_data  = '0;
        bus.stall    = 1'b0;
        bus.fwd_addr = '0;
        @(posedge clk);
        do_reset(1'b1);

        // Single write: pulse on bit 3 for exactly one cycle after the pop edge.
        step(1'b1, 3'd3, 16'h1234, 1'b0, 3'd3);
        step(1'b0, 3'd0, 16'h0, 1'b0, 3'd3);
        check("tp1_wr_en", 32'(bus.wr_en), 32'h08);
        check("tp1_wr_d", 32'(bus.wr_d), 32'h1234);
        step(1'b0, 3'd0, 16'h0, 1'b0, 3'd3);
        check("tp1_wr_en_off", 32'(bus.wr_en), 32'h00);
        check("tp1_wr_d_hold", 32'(bus.wr_d), 32'h1234);

        // Stall fill: fifth push is refused, then four pulses in order.
        for (int i = 0; i < 5; i++) step(1'b1, 3'(i), 16'(16'h0B00 + i), 1'b1, 3'(i));
        check("tp2_full", 32'(bus.full), 32'd1);
        idle(6, 3'd4);

        // Forwarding of two writes to the same register.
        step(1'b1, 3'd2, 16'h0001, 1'b1, 3'd2);
        step(1'b1, 3'd2, 16'h0002, 1'b1, 3'd2);
        step(1'b0, 3'd0, 16'h0, 1'b1, 3'd2);
        check("tp3_fwd_newest", 32'(bus.fwd_data), 32'h0002);
        idle(4, 3'd2);
        check("tp3_fwd_gone", 32'(bus.fwd_hit), 32'd0);

        // Streaming: one in, one out per cycle across pointer wrap.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 3'(i), 16'(16'hA000 + i), 1'b0, 3'(i));
            check("tp4_count_le1", 32'(bus.count <= 1), 32'd1);
        end
        idle(3, 3'd0);

        // Reset with three entries queued and a request on the bus.
        for (int i = 0; i < 3; i++) step(1'b1, 3'd5, 16'(16'hC000 + i), 1'b1, 3'd5);
        do_reset(1'b1);
        idle(4, 3'd5);

        // Address 7 with a non-matching lookup.
        step(1'b1, 3'd7, 16'hBEEF, 1'b0, 3'd6);
        step(1'b0, 3'd0, 16'h0, 1'b0, 3'd6);
        check("tp6_wr_en", 32'(bus.wr_en), 32'h80);
        idle(2, 3'd6);

        // Random traffic with occasional resets mid-stream.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) do_reset(1'($urandom_range(0, 1)));
            else step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 16'($urandom),
                      1'($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)));
        end
        idle(6, 3'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
